// File: rtl/uart_echo_buffer.sv
// Buffered echo engine between uart_rx and uart_tx: received bytes are queued,
// optionally case-converted, and retransmitted with optional CR -> CR LF expansion.
module uart_echo_buffer #(
  parameter int DEPTH_LOG2  = 4,
  parameter int CASE_MODE   = 0,
  parameter bit CRLF_EXPAND = 1'b1
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic [7:0]            rx_data,
  input  logic                  rx_valid,
  input  logic                  echo_en,
  input  logic                  tx_busy,
  output logic [7:0]            tx_data,
  output logic                  tx_we,
  output logic [DEPTH_LOG2:0]   fifo_level,
  output logic                  overflow,
  output logic [7:0]            drop_count,
  input  logic                  clear_overflow
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] FULL_LEVEL = {1'b1, {DEPTH_LOG2{1'b0}}};

  typedef enum logic [1:0] {
    S_IDLE,
    S_GUARD,
    S_WAIT,
    S_LF
  } state_t;

  logic [7:0]            mem_q [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
  logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
  logic [DEPTH_LOG2:0]   level_q, level_d;
  state_t                state_q, state_d;
  logic [7:0]            tx_data_q, tx_data_d;
  logic                  tx_we_q, tx_we_d;
  logic                  lf_pend_q, lf_pend_d;
  logic                  overflow_q, overflow_d;
  logic [7:0]            drop_q, drop_d;

  logic                  wr_req, push, pop, drop;
  logic [7:0]            wr_byte, head_byte;

  function automatic logic [7:0] case_xform(input logic [7:0] b);
    logic [7:0] r;
    r = b;
    if (CASE_MODE == 1 && b >= 8'h61 && b <= 8'h7A) begin
      r = b - 8'h20;
    end else if (CASE_MODE == 2 && b >= 8'h41 && b <= 8'h5A) begin
      r = b + 8'h20;
    end
    return r;
  endfunction

  // Full test uses the registered level only, so a same-cycle pop never frees a slot.
  always_comb begin
    wr_req    = rx_valid && echo_en;
    push      = wr_req && (level_q != FULL_LEVEL);
    drop      = wr_req && (level_q == FULL_LEVEL);
    wr_byte   = case_xform(rx_data);
    head_byte = mem_q[rd_ptr_q];
  end

  always_comb begin
    state_d   = state_q;
    tx_data_d = tx_data_q;
    tx_we_d   = 1'b0;
    lf_pend_d = lf_pend_q;
    pop       = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (level_q != '0 && !tx_busy) begin
          tx_data_d = head_byte;
          tx_we_d   = 1'b1;
          pop       = 1'b1;
          lf_pend_d = CRLF_EXPAND && (head_byte == 8'h0D);
          state_d   = S_GUARD;
        end
      end
      S_GUARD: state_d = S_WAIT;
      S_WAIT: begin
        if (!tx_busy) begin
          state_d = lf_pend_q ? S_LF : S_IDLE;
        end
      end
      S_LF: begin
        tx_data_d = 8'h0A;
        tx_we_d   = 1'b1;
        lf_pend_d = 1'b0;
        state_d   = S_GUARD;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (push) wr_ptr_d = wr_ptr_q + DEPTH_LOG2'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + DEPTH_LOG2'(1);
    case ({push, pop})
      2'b10:   level_d = level_q + (DEPTH_LOG2+1)'(1);
      2'b01:   level_d = level_q - (DEPTH_LOG2+1)'(1);
      default: level_d = level_q;
    endcase
  end

  // A drop coinciding with clear restarts the count at one rather than zero.
  always_comb begin
    overflow_d = overflow_q;
    drop_d     = drop_q;
    if (drop) begin
      overflow_d = 1'b1;
      if (clear_overflow)      drop_d = 8'd1;
      else if (drop_q != 8'hFF) drop_d = drop_q + 8'd1;
    end else if (clear_overflow) begin
      overflow_d = 1'b0;
      drop_d     = 8'd0;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      state_q    <= S_IDLE;
      tx_data_q  <= 8'h00;
      tx_we_q    <= 1'b0;
      lf_pend_q  <= 1'b0;
      overflow_q <= 1'b0;
      drop_q     <= 8'd0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      state_q    <= state_d;
      tx_data_q  <= tx_data_d;
      tx_we_q    <= tx_we_d;
      lf_pend_q  <= lf_pend_d;
      overflow_q <= overflow_d;
      drop_q     <= drop_d;
    end
  end

  always_ff @(posedge clk) begin
    if (resetn && push) begin
      mem_q[wr_ptr_q] <= wr_byte;
    end
  end

  assign tx_data    = tx_data_q;
  assign tx_we      = tx_we_q;
  assign fifo_level = level_q;
  assign overflow   = overflow_q;
  assign drop_count = drop_q;

endmodule

// File: tb/tb_uart_echo_buffer.sv
// Scoreboard bench: two echo buffers (depth 4 / upper-case / CRLF, depth 8 / lower-case / no CRLF)
// share rx stimulus; expected tx bytes are queued at issue time and popped by a negedge monitor.
module tb_uart_echo_buffer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            resetn, rx_valid, echo_en, clear_overflow, hold_busy;
  logic [7:0]      rx_data;
  logic [1:0]      tx_busy, tx_we, overflow;
  logic [1:0][7:0] tx_data, drop_count;
  logic [2:0]      level_a;
  logic [3:0]      level_b;
  int              busy_cnt [2];

  int n_vec = 0;
  int n_err = 0;
  int pushed [2];
  int popped [2];
  int drops  [2];
  logic [8:0] exp_q [2][$];

  uart_echo_buffer #(.DEPTH_LOG2(2), .CASE_MODE(1), .CRLF_EXPAND(1'b1)) dut_a (
    .clk(clk), .resetn(resetn), .rx_data(rx_data), .rx_valid(rx_valid), .echo_en(echo_en),
    .tx_busy(tx_busy[0]), .tx_data(tx_data[0]), .tx_we(tx_we[0]), .fifo_level(level_a),
    .overflow(overflow[0]), .drop_count(drop_count[0]), .clear_overflow(clear_overflow));

  uart_echo_buffer #(.DEPTH_LOG2(3), .CASE_MODE(2), .CRLF_EXPAND(1'b0)) dut_b (
    .clk(clk), .resetn(resetn), .rx_data(rx_data), .rx_valid(rx_valid), .echo_en(echo_en),
    .tx_busy(tx_busy[1]), .tx_data(tx_data[1]), .tx_we(tx_we[1]), .fifo_level(level_b),
    .overflow(overflow[1]), .drop_count(drop_count[1]), .clear_overflow(clear_overflow));

  // Transmitter model: busy from the cycle after tx_we for a random frame length.
  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (tx_we[i]) busy_cnt[i] <= $urandom_range(1, 12);
      else if (busy_cnt[i] > 0) busy_cnt[i] <= busy_cnt[i] - 1;
    end
  end
  assign tx_busy[0] = hold_busy || (busy_cnt[0] != 0);
  assign tx_busy[1] = hold_busy || (busy_cnt[1] != 0);

  function automatic int depth(input int i);
    return (i == 0) ? 4 : 8;
  endfunction

  function automatic int lvl(input int i);
    return (i == 0) ? int'(level_a) : int'(level_b);
  endfunction

  function automatic int model_lvl(input int i);
    return pushed[i] - popped[i];
  endfunction

  function automatic logic [7:0] xform(input int i, input logic [7:0] b);
    if (i == 0 && b >= 8'h61 && b <= 8'h7A) return b - 8'd32;
    if (i == 1 && b >= 8'h41 && b <= 8'h5A) return b + 8'd32;
    return b;
  endfunction

  function automatic logic [7:0] rand_byte();
    case ($urandom_range(0, 3))
      0:       return 8'h0D;
      1:       return 8'h61 + 8'($urandom_range(0, 25));
      2:       return 8'h41 + 8'($urandom_range(0, 25));
      default: return 8'($urandom_range(0, 255));
    endcase
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: pops the scoreboard on every tx_we and checks framing invariants each cycle.
  logic [1:0]      prev_we;
  logic [1:0][7:0] last_data;
  always @(negedge clk) begin : monitor
    logic [8:0] e;
    int m;
    for (int i = 0; i < 2; i++) begin
      if (!resetn) begin
        exp_q[i].delete();
        popped[i]    = pushed[i];
        last_data[i] = 8'h00;
        prev_we[i]   = 1'b0;
      end else begin
        if (tx_we[i]) begin
          chk($sformatf("tx_we_back_to_back%0d", i), int'(prev_we[i]), 0);
          if (exp_q[i].size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL unexpected_tx%0d: got 0x%02h, required no transmission", i, tx_data[i]);
            last_data[i] = tx_data[i];
          end else begin
            e = exp_q[i].pop_front();
            chk($sformatf("tx_data%0d", i), int'(tx_data[i]), int'(e[7:0]));
            if (!e[8]) popped[i]++;
            last_data[i] = e[7:0];
          end
        end else begin
          chk($sformatf("tx_data_hold%0d", i), int'(tx_data[i]), int'(last_data[i]));
        end
        prev_we[i] = tx_we[i];
        m = model_lvl(i);
        n_vec++;
        if (lvl(i) > m || lvl(i) < m - 1) begin
          n_err++;
          $display("FAIL fifo_level_bound%0d: got %0d, required %0d or %0d", i, lvl(i), m - 1, m);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic send(input logic [7:0] b, input logic clr);
    logic [7:0] x;
    logic dropped;
    rx_data        = b;
    rx_valid       = 1'b1;
    clear_overflow = clr;
    for (int i = 0; i < 2; i++) begin
      dropped = 1'b0;
      if (echo_en) begin
        if (model_lvl(i) < depth(i)) begin
          x = xform(i, b);
          exp_q[i].push_back({1'b0, x});
          if (i == 0 && x == 8'h0D) exp_q[i].push_back(9'h10A);
          pushed[i]++;
        end else begin
          dropped = 1'b1;
        end
      end
      if (dropped)  drops[i] = clr ? 1 : drops[i] + 1;
      else if (clr) drops[i] = 0;
    end
    tick();
    rx_valid       = 1'b0;
    clear_overflow = 1'b0;
  endtask

  task automatic chk_status(input string tag);
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("%s_level%0d", tag, i), lvl(i), model_lvl(i));
      chk($sformatf("%s_overflow%0d", tag, i), int'(overflow[i]), int'(drops[i] > 0));
      chk($sformatf("%s_drop_count%0d", tag, i), int'(drop_count[i]), (drops[i] > 255) ? 255 : drops[i]);
    end
  endtask

  task automatic drain(input string tag);
    int t;
    t = 0;
    hold_busy = 1'b0;
    while ((exp_q[0].size() != 0 || exp_q[1].size() != 0) && t < 3000) begin
      tick();
      t++;
    end
    chk({tag, "_drain_in_time"}, int'(t < 3000), 1);
    idle(20);
    chk_status(tag);
  endtask

  task automatic clear_pulse();
    clear_overflow = 1'b1;
    drops[0] = 0;
    drops[1] = 0;
    tick();
    clear_overflow = 1'b0;
    tick();
  endtask

  initial begin
    int we_seen;
    resetn = 1'b0; rx_valid = 1'b0; echo_en = 1'b1; clear_overflow = 1'b0;
    hold_busy = 1'b0; rx_data = 8'h00;
    drops[0] = 0; drops[1] = 0;
    idle(3);
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("reset_tx_we%0d", i), int'(tx_we[i]), 0);
      chk($sformatf("reset_tx_data%0d", i), int'(tx_data[i]), 0);
      chk($sformatf("reset_level%0d", i), lvl(i), 0);
      chk($sformatf("reset_overflow%0d", i), int'(overflow[i]), 0);
      chk($sformatf("reset_drop_count%0d", i), int'(drop_count[i]), 0);
    end
    resetn = 1'b1;
    idle(5);

    // Latency: rx in cycle N -> tx_we in cycle N+2.
    send(8'h41, 1'b0);
    chk("latency_n1_tx_we", int'(tx_we[0]), 0);
    chk("latency_n1_level", lvl(0), 1);
    tick();
    chk("latency_n2_tx_we_a", int'(tx_we[0]), 1);
    chk("latency_n2_tx_we_b", int'(tx_we[1]), 1);
    chk("latency_n2_tx_data_a", int'(tx_data[0]), 8'h41);
    chk("latency_n2_tx_data_b", int'(tx_data[1]), 8'h61);
    chk("latency_n2_level", lvl(0), 0);
    drain("latency");

    send(8'h61, 1'b0); send(8'h5A, 1'b0); send(8'h7B, 1'b0);
    drain("case");

    send(8'h0D, 1'b0); send(8'h31, 1'b0);
    drain("crlf");

    // Overflow with the transmitter stalled.
    hold_busy = 1'b1;
    for (int j = 0; j < 6; j++) send(8'h62 + 8'(j), 1'b0);
    idle(2);
    chk("stall_level_a", lvl(0), 4);
    chk("stall_drop_count_a", int'(drop_count[0]), 2);
    chk_status("stall");
    drain("stall_release");
    clear_pulse();
    chk_status("cleared");

    // Full FIFO: pop and rx in the same cycle -> byte dropped.
    hold_busy = 1'b1;
    send(8'h70, 1'b0); send(8'h71, 1'b0); send(8'h72, 1'b0); send(8'h73, 1'b0);
    idle(1);
    hold_busy = 1'b0;
    send(8'h74, 1'b0);
    hold_busy = 1'b1;
    chk("pop_and_drop_level_a", lvl(0), 3);
    chk("pop_and_drop_count_a", int'(drop_count[0]), 1);
    idle(2);
    chk_status("pop_and_drop");
    for (int j = 0; j < 300; j++) send(rand_byte(), 1'b0);
    idle(1);
    chk("saturate_count_a", int'(drop_count[0]), 255);
    chk_status("saturate");
    send(8'h55, 1'b1);
    idle(1);
    chk("drop_beats_clear_a", int'(drop_count[0]), 1);
    chk_status("drop_beats_clear");
    clear_pulse();
    chk_status("cleared2");
    drain("saturate_release");

    // Reset while waiting on the transmitter with bytes queued.
    send(8'h6B, 1'b0); send(8'h6C, 1'b0); send(8'h6D, 1'b0); send(8'h6E, 1'b0);
    hold_busy = 1'b1;
    idle(3);
    chk("pre_reset_level_a", lvl(0), 3);
    resetn = 1'b0;
    drops[0] = 0;
    drops[1] = 0;
    tick();
    resetn = 1'b1;
    hold_busy = 1'b0;
    chk("mid_reset_level_a", lvl(0), 0);
    chk("mid_reset_level_b", lvl(1), 0);
    chk("mid_reset_tx_we_a", int'(tx_we[0]), 0);
    chk("mid_reset_tx_we_b", int'(tx_we[1]), 0);
    we_seen = 0;
    for (int j = 0; j < 40; j++) begin
      tick();
      we_seen += int'(tx_we[0]) + int'(tx_we[1]);
    end
    chk("no_tx_after_reset", we_seen, 0);
    echo_en = 1'b0;
    send(8'h41, 1'b0); send(8'h0D, 1'b0); send(8'h7A, 1'b0);
    idle(5);
    chk_status("echo_disabled");
    echo_en = 1'b1;

    // Randomized traffic with random transmitter frame lengths.
    for (int j = 0; j < 800; j++) begin
      echo_en = ($urandom_range(0, 9) != 0);
      if ($urandom_range(0, 2) == 0 &&
          (!echo_en || (model_lvl(0) < depth(0) && model_lvl(1) < depth(1)))) begin
        send(rand_byte(), 1'b0);
      end else begin
        tick();
      end
    end
    echo_en = 1'b1;
    drain("random");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
